uart_tx_fifo: RTL

Byte buffer and launch controller that sits directly upstream of the UART transmitter. Producers write bytes at full clock rate. The block queues them in a circular FIFO and launches them one at a time into the transmitter using the transmitter's `tx_start` / `tx_data` / `tx_busy` handshake. Each new byte is launched only after the previous frame has completely finished.

---
 rtl/uart_tx_fifo.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte queue and launch controller feeding a UART transmitter. Producers push
// bytes at full clock rate into a circular FIFO; a small FSM pops one byte at
// a time and hands it to the transmitter through tx_start / tx_data / tx_busy,
// launching the next byte only after the previous frame has fully finished.
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   wr_en     in   producer write request
//   wr_data   in   byte to queue
//   full      out  FIFO holds DEPTH bytes
//   empty     out  FIFO holds no bytes
//   count     out  queued bytes (excludes the byte in flight)
//   overflow  out  one-cycle pulse per write dropped while full
//   idle      out  empty, FSM in IDLE and transmitter not busy
//   tx_start  out  one-cycle launch pulse (registered)
//   tx_data   out  byte presented to the transmitter, held between pops
//   tx_busy   in   transmitter busy flag, rises the cycle after tx_start
//
// Launch FSM
//   state   | meaning
//   S_IDLE  | waiting for a queued byte and a free transmitter; pops on entry to START
//   S_START | tx_start high for this single cycle
//   S_ACK   | waiting for tx_busy to rise (it is still low while tx_start is sampled)
//   S_DRAIN | waiting for tx_busy to fall, i.e. the frame to complete

module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          idle,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_ACK,
        S_DRAIN
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    // Flags come from the registered count, so a write seen while full is
    // dropped even if a pop frees a slot in the same cycle.
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign push  = wr_en && !full;
    assign pop   = (state == S_IDLE) && !empty && !tx_busy;
    assign idle  = empty && (state == S_IDLE) && !tx_busy;

    // Storage is not reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            overflow <= wr_en && full;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            case (state)
                S_IDLE: begin
                    tx_start <= 1'b0;
                    if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        rd_ptr   <= rd_ptr + AW'(1);
                        tx_start <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    tx_start <= 1'b0;
                    state    <= S_ACK;
                end
                S_ACK: begin
                    tx_start <= 1'b0;
                    if (tx_busy) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    tx_start <= 1'b0;
                    if (!tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
